ahb3lite_interconnect_slave_port: RTL and testbench

Per-slave arbitration and multiplexing stage of the AHB3-Lite multi-layer switch, sitting directly downstream of the master ports. It collects connection requests from all master ports for one AHB slave and arbitrates between them by priority, with an optional round-robin tie-break. It drives the selected master's address/control to the slave, steers HWDATA by data-phase owner, and returns the slave's response to all master ports.

---
 rtl/ahb3lite_interconnect_slave_port.sv | 150 +++++++++++++++
 tb/tb_ahb3lite_interconnect_slave_port.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_interconnect_slave_port.sv
// Per-slave arbitration and address/data multiplexing stage of the AHB3-Lite multi-layer switch.
// Define AHB3LITE_SLAVE_PORT_RR_EN for round-robin resolution of equal-priority requests.
module ahb3lite_interconnect_slave_port #(
  parameter  int HADDR_SIZE  = 32,
  parameter  int HDATA_SIZE  = 32,
  parameter  int MASTERS     = 3,
  localparam int MASTER_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,

  input  logic [MASTER_BITS-1:0] mstpriority    [MASTERS],
  input  logic [MASTERS-1:0]     mstHSEL,
  input  logic [HADDR_SIZE-1:0]  mstHADDR       [MASTERS],
  input  logic [HDATA_SIZE-1:0]  mstHWDATA      [MASTERS],
  input  logic [MASTERS-1:0]     mstHWRITE,
  input  logic [2:0]             mstHSIZE       [MASTERS],
  input  logic [2:0]             mstHBURST      [MASTERS],
  input  logic [3:0]             mstHPROT       [MASTERS],
  input  logic [1:0]             mstHTRANS      [MASTERS],
  input  logic [MASTERS-1:0]     mstHMASTLOCK,
  input  logic [MASTERS-1:0]     mstHREADY,
  input  logic [MASTERS-1:0]     mst_can_switch,
  output logic [MASTERS-1:0]     mst_granted,

  output logic [HDATA_SIZE-1:0]  mstHRDATA,
  output logic                   mstHREADYOUT,
  output logic                   mstHRESP,

  output logic                   slv_HSEL,
  output logic [HADDR_SIZE-1:0]  slv_HADDR,
  output logic [HDATA_SIZE-1:0]  slv_HWDATA,
  output logic                   slv_HWRITE,
  output logic [2:0]             slv_HSIZE,
  output logic [2:0]             slv_HBURST,
  output logic [3:0]             slv_HPROT,
  output logic [1:0]             slv_HTRANS,
  output logic                   slv_HMASTLOCK,
  output logic                   slv_HREADY,

  input  logic [HDATA_SIZE-1:0]  slv_HRDATA,
  input  logic                   slv_HREADYOUT,
  input  logic                   slv_HRESP
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  logic [MASTER_BITS-1:0] granted_master;
  logic [MASTER_BITS-1:0] data_owner;
  logic [MASTER_BITS-1:0] arb_master;
  logic [MASTER_BITS-1:0] best_prio;
  logic                   found;
  int unsigned            idx;

  logic                   sel_hsel;
  logic [1:0]             sel_htrans;
  logic                   sel_can_switch;

  // Strict '>' keeps the first requester seen in scan order on a priority tie.
  always_comb begin
    arb_master = granted_master;
    best_prio  = '0;
    found      = 1'b0;
    idx        = 0;
`ifdef AHB3LITE_SLAVE_PORT_RR_EN
    // Scan starts just after the current owner so the owner itself is considered last.
    for (int unsigned k = 1; k <= int'(MASTERS); k++) begin
      idx = (32'(granted_master) + k) % 32'(MASTERS);
      if (mstHSEL[idx] && (!found || mstpriority[idx] > best_prio)) begin
        found      = 1'b1;
        best_prio  = mstpriority[idx];
        arb_master = MASTER_BITS'(idx);
      end
    end
`else
    for (int unsigned i = 0; i < int'(MASTERS); i++) begin
      idx = i;
      if (mstHSEL[idx] && (!found || mstpriority[idx] > best_prio)) begin
        found      = 1'b1;
        best_prio  = mstpriority[idx];
        arb_master = MASTER_BITS'(idx);
      end
    end
`endif
  end

  // Address-phase mux; an unreachable out-of-range owner index falls back to master 0.
  always_comb begin
    sel_hsel       = mstHSEL[0];
    slv_HADDR      = mstHADDR[0];
    slv_HWRITE     = mstHWRITE[0];
    slv_HSIZE      = mstHSIZE[0];
    slv_HBURST     = mstHBURST[0];
    slv_HPROT      = mstHPROT[0];
    sel_htrans     = mstHTRANS[0];
    slv_HMASTLOCK  = mstHMASTLOCK[0];
    slv_HREADY     = mstHREADY[0];
    sel_can_switch = mst_can_switch[0];
    for (int unsigned i = 1; i < int'(MASTERS); i++) begin
      if (granted_master == MASTER_BITS'(i)) begin
        sel_hsel       = mstHSEL[i];
        slv_HADDR      = mstHADDR[i];
        slv_HWRITE     = mstHWRITE[i];
        slv_HSIZE      = mstHSIZE[i];
        slv_HBURST     = mstHBURST[i];
        slv_HPROT      = mstHPROT[i];
        sel_htrans     = mstHTRANS[i];
        slv_HMASTLOCK  = mstHMASTLOCK[i];
        slv_HREADY     = mstHREADY[i];
        sel_can_switch = mst_can_switch[i];
      end
    end
  end

  always_comb begin
    slv_HSEL   = sel_hsel;
    slv_HTRANS = sel_hsel ? sel_htrans : HTRANS_IDLE;
  end

  always_comb begin
    slv_HWDATA = mstHWDATA[0];
    for (int unsigned i = 1; i < int'(MASTERS); i++) begin
      if (data_owner == MASTER_BITS'(i)) slv_HWDATA = mstHWDATA[i];
    end
  end

  always_comb begin
    mst_granted = '0;
    for (int unsigned i = 0; i < int'(MASTERS); i++) begin
      if (granted_master == MASTER_BITS'(i)) mst_granted[i] = 1'b1;
    end
  end

  always_comb begin
    mstHRDATA    = slv_HRDATA;
    mstHREADYOUT = slv_HREADYOUT;
    mstHRESP     = slv_HRESP;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      granted_master <= '0;
      data_owner     <= '0;
    end else begin
      if (sel_can_switch && slv_HREADYOUT) granted_master <= arb_master;
      if (slv_HREADY)                      data_owner     <= granted_master;
    end
  end

endmodule

// File: tb/tb_ahb3lite_interconnect_slave_port.sv
// Scoreboard bench for ahb3lite_interconnect_slave_port: directed scenarios followed by random traffic.
module tb_ahb3lite_interconnect_slave_port;

  localparam int M  = 3;
  localparam int MB = 2;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [MB-1:0] mstpriority  [M];
  logic [M-1:0]  mstHSEL;
  logic [31:0]   mstHADDR     [M];
  logic [31:0]   mstHWDATA    [M];
  logic [M-1:0]  mstHWRITE;
  logic [2:0]    mstHSIZE     [M];
  logic [2:0]    mstHBURST    [M];
  logic [3:0]    mstHPROT     [M];
  logic [1:0]    mstHTRANS    [M];
  logic [M-1:0]  mstHMASTLOCK;
  logic [M-1:0]  mstHREADY;
  logic [M-1:0]  mst_can_switch;
  logic [M-1:0]  mst_granted;
  logic [31:0]   mstHRDATA;
  logic          mstHREADYOUT, mstHRESP;
  logic          slv_HSEL;
  logic [31:0]   slv_HADDR, slv_HWDATA;
  logic          slv_HWRITE;
  logic [2:0]    slv_HSIZE, slv_HBURST;
  logic [3:0]    slv_HPROT;
  logic [1:0]    slv_HTRANS;
  logic          slv_HMASTLOCK, slv_HREADY;
  logic [31:0]   slv_HRDATA;
  logic          slv_HREADYOUT, slv_HRESP;

  ahb3lite_interconnect_slave_port #(
    .HADDR_SIZE(32),
    .HDATA_SIZE(32),
    .MASTERS   (M)
  ) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .mstpriority   (mstpriority),
    .mstHSEL       (mstHSEL),
    .mstHADDR      (mstHADDR),
    .mstHWDATA     (mstHWDATA),
    .mstHWRITE     (mstHWRITE),
    .mstHSIZE      (mstHSIZE),
    .mstHBURST     (mstHBURST),
    .mstHPROT      (mstHPROT),
    .mstHTRANS     (mstHTRANS),
    .mstHMASTLOCK  (mstHMASTLOCK),
    .mstHREADY     (mstHREADY),
    .mst_can_switch(mst_can_switch),
    .mst_granted   (mst_granted),
    .mstHRDATA     (mstHRDATA),
    .mstHREADYOUT  (mstHREADYOUT),
    .mstHRESP      (mstHRESP),
    .slv_HSEL      (slv_HSEL),
    .slv_HADDR     (slv_HADDR),
    .slv_HWDATA    (slv_HWDATA),
    .slv_HWRITE    (slv_HWRITE),
    .slv_HSIZE     (slv_HSIZE),
    .slv_HBURST    (slv_HBURST),
    .slv_HPROT     (slv_HPROT),
    .slv_HTRANS    (slv_HTRANS),
    .slv_HMASTLOCK (slv_HMASTLOCK),
    .slv_HREADY    (slv_HREADY),
    .slv_HRDATA    (slv_HRDATA),
    .slv_HREADYOUT (slv_HREADYOUT),
    .slv_HRESP     (slv_HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [M-1:0] granted;
    logic         hsel;
    logic [31:0]  haddr;
    logic         hwrite;
    logic [2:0]   hsize;
    logic [2:0]   hburst;
    logic [3:0]   hprot;
    logic [1:0]   htrans;
    logic         hlock;
    logic         hready;
    logic [31:0]  hwdata;
    logic [31:0]  hrdata;
    logic         hreadyout;
    logic         hresp;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   drv_done = 0;
  int   m_owner = 0;
  int   m_downer = 0;

  // Reference arbitration: highest priority among requesters; ties by lowest index,
  // or (round-robin) by smallest forward distance from the slot after the owner.
  function automatic int ref_arb(int owner);
    int maxp = -1;
    int best = -1;
    int bestd = M + 1;
    for (int m = 0; m < M; m++)
      if (mstHSEL[m] && int'(mstpriority[m]) > maxp) maxp = int'(mstpriority[m]);
    if (maxp < 0) return owner;
    for (int m = 0; m < M; m++) begin
      if (mstHSEL[m] && int'(mstpriority[m]) == maxp) begin
`ifdef AHB3LITE_SLAVE_PORT_RR_EN
        int d = (m - owner - 1 + 2 * M) % M;
        if (d < bestd) begin bestd = d; best = m; end
`else
        if (best < 0) best = m;
`endif
      end
    end
    return best;
  endfunction

  task automatic check_and_advance();
    exp_t e;
    int   nxt;
    #1;
    if (!HRESETn) begin m_owner = 0; m_downer = 0; end
    e.granted   = '0;
    e.granted[m_owner] = 1'b1;
    e.hsel      = mstHSEL[m_owner];
    e.haddr     = mstHADDR[m_owner];
    e.hwrite    = mstHWRITE[m_owner];
    e.hsize     = mstHSIZE[m_owner];
    e.hburst    = mstHBURST[m_owner];
    e.hprot     = mstHPROT[m_owner];
    e.htrans    = e.hsel ? mstHTRANS[m_owner] : 2'b00;
    e.hlock     = mstHMASTLOCK[m_owner];
    e.hready    = mstHREADY[m_owner];
    e.hwdata    = mstHWDATA[m_downer];
    e.hrdata    = slv_HRDATA;
    e.hreadyout = slv_HREADYOUT;
    e.hresp     = slv_HRESP;
    exp_q.push_back(e);
    if (HRESETn) begin
      nxt = (mst_can_switch[m_owner] && slv_HREADYOUT) ? ref_arb(m_owner) : m_owner;
      if (mstHREADY[m_owner]) m_downer = m_owner;
      m_owner = nxt;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares every queued expectation against the DUT outputs of that cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mst_granted",   32'(mst_granted),   32'(e.granted));
        chk("slv_HSEL",      32'(slv_HSEL),      32'(e.hsel));
        chk("slv_HTRANS",    32'(slv_HTRANS),    32'(e.htrans));
        chk("slv_HREADY",    32'(slv_HREADY),    32'(e.hready));
        chk("slv_HWDATA",    slv_HWDATA,         e.hwdata);
        chk("mstHRDATA",     mstHRDATA,          e.hrdata);
        chk("mstHREADYOUT",  32'(mstHREADYOUT),  32'(e.hreadyout));
        chk("mstHRESP",      32'(mstHRESP),      32'(e.hresp));
        if (e.hsel) begin
          chk("slv_HADDR",     slv_HADDR,          e.haddr);
          chk("slv_HWRITE",    32'(slv_HWRITE),    32'(e.hwrite));
          chk("slv_HSIZE",     32'(slv_HSIZE),     32'(e.hsize));
          chk("slv_HBURST",    32'(slv_HBURST),    32'(e.hburst));
          chk("slv_HPROT",     32'(slv_HPROT),     32'(e.hprot));
          chk("slv_HMASTLOCK", 32'(slv_HMASTLOCK), 32'(e.hlock));
        end
      end
    end
  end

  task automatic all_idle();
    mstHSEL = '0; mstHWRITE = '0; mstHMASTLOCK = '0;
    mstHREADY = '1; mst_can_switch = '1;
    slv_HREADYOUT = 1'b1; slv_HRESP = 1'b0; slv_HRDATA = 32'h0;
    for (int m = 0; m < M; m++) begin
      mstpriority[m] = '0; mstHADDR[m] = 32'h0; mstHWDATA[m] = 32'h0;
      mstHSIZE[m] = 3'd2; mstHBURST[m] = 3'd0; mstHPROT[m] = 4'h3; mstHTRANS[m] = 2'b00;
    end
  endtask

  task automatic req(input int m, input logic [31:0] addr, input logic wr);
    mstHSEL[m] = 1'b1; mstHADDR[m] = addr; mstHWRITE[m] = wr; mstHTRANS[m] = 2'b10;
  endtask

  task automatic randomize_inputs();
    HRESETn = ($urandom_range(63) != 0);
    slv_HREADYOUT = ($urandom_range(4) != 0);
    slv_HRESP = ($urandom_range(7) == 0);
    slv_HRDATA = $urandom;
    for (int m = 0; m < M; m++) begin
      mstpriority[m] = MB'($urandom_range(3));
      mstHSEL[m] = $urandom_range(1);
      mstHADDR[m] = $urandom;
      mstHWDATA[m] = $urandom;
      mstHWRITE[m] = $urandom_range(1);
      mstHSIZE[m] = 3'($urandom_range(7));
      mstHBURST[m] = 3'($urandom_range(7));
      mstHPROT[m] = 4'($urandom_range(15));
      mstHTRANS[m] = 2'($urandom_range(3));
      mstHMASTLOCK[m] = $urandom_range(1);
      mstHREADY[m] = ($urandom_range(5) == 0) ? ~slv_HREADYOUT : slv_HREADYOUT;
      mst_can_switch[m] = ($urandom_range(3) != 0);
    end
  endtask

  initial begin
    HRESETn = 1'b0;
    all_idle();
    // Reset with no requests
    repeat (2) begin @(negedge HCLK); check_and_advance(); end
    @(negedge HCLK); HRESETn = 1'b1; check_and_advance();
    // Parked master 0 write to 0x100, data phase next cycle
    @(negedge HCLK); req(0, 32'h100, 1'b1); check_and_advance();
    @(negedge HCLK); mstHSEL[0] = 1'b0; mstHTRANS[0] = 2'b00; mstHWDATA[0] = 32'hDEADBEEF; check_and_advance();
    // Masters 1 (prio 1) and 2 (prio 2) compete
    @(negedge HCLK); mstpriority[1] = 2'd1; mstpriority[2] = 2'd2;
    req(1, 32'h200, 1'b0); req(2, 32'h300, 1'b1); mst_can_switch[2] = 1'b0; check_and_advance();
    @(negedge HCLK); check_and_advance();
    @(negedge HCLK); mstHSEL[2] = 1'b0; mst_can_switch[2] = 1'b1; check_and_advance();
    @(negedge HCLK); check_and_advance();
    // Locked owner (master 1) while master 2 requests
    @(negedge HCLK); mst_can_switch[1] = 1'b0; mstHMASTLOCK[1] = 1'b1; mstHBURST[1] = 3'd3;
    req(2, 32'h340, 1'b1); check_and_advance();
    repeat (2) begin @(negedge HCLK); check_and_advance(); end
    @(negedge HCLK); mst_can_switch[1] = 1'b1; mstHMASTLOCK[1] = 1'b0; check_and_advance();
    @(negedge HCLK); check_and_advance();
    // Slave wait states during a switch request
    @(negedge HCLK); mstpriority[1] = 2'd3; mstHWDATA[1] = 32'h11111111; mstHWDATA[2] = 32'h22222222;
    slv_HREADYOUT = 1'b0; mstHREADY = '0; check_and_advance();
    repeat (2) begin @(negedge HCLK); check_and_advance(); end
    @(negedge HCLK); slv_HREADYOUT = 1'b1; mstHREADY = '1; check_and_advance();
    @(negedge HCLK); check_and_advance();
    // Equal priority, continuous requests
    @(negedge HCLK); mstpriority[1] = 2'd1; mstpriority[2] = 2'd1; check_and_advance();
    repeat (6) begin @(negedge HCLK); check_and_advance(); end
    // Random traffic including occasional mid-transfer resets
    repeat (2000) begin
      @(negedge HCLK); randomize_inputs(); check_and_advance();
    end
    drv_done = 1;
  end

  initial begin
    int waited = 0;
    while (!drv_done && waited < 5000) begin @(posedge HCLK); waited++; end
    repeat (3) @(posedge HCLK);
    tests++;
    if (!drv_done || exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: driver_done=%0d pending=%0d expected done=1 pending=0", drv_done, exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
